// File: rtl/snn_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_ctrl_pkg - state encoding and shared defaults for snn_layer_controller
// Revision 1.0
// ----------------------------------------------------------------------------
package snn_ctrl_pkg;

  localparam logic [3:0] ST_INIT  = 4'd0;
  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_PULL  = 4'd2;
  localparam logic [3:0] ST_LATCH = 4'd3;
  localparam logic [3:0] ST_GAP   = 4'd4;
  localparam logic [3:0] ST_ISSUE = 4'd5;
  localparam logic [3:0] ST_TIDY  = 4'd6;
  localparam logic [3:0] ST_DUMP0 = 4'd7;
  localparam logic [3:0] ST_DUMP1 = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  typedef enum logic [3:0] {
    S_INIT  = ST_INIT,
    S_IDLE  = ST_IDLE,
    S_PULL  = ST_PULL,
    S_LATCH = ST_LATCH,
    S_GAP   = ST_GAP,
    S_ISSUE = ST_ISSUE,
    S_TIDY  = ST_TIDY,
    S_DUMP0 = ST_DUMP0,
    S_DUMP1 = ST_DUMP1,
    S_DONE  = ST_DONE
  } state_t;

  localparam int DEFAULT_INIT_VOL = 63;

endpackage
`default_nettype wire

// File: rtl/snn_layer_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_layer_controller_if - offset memory, CSR beat and voltage-control bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface snn_layer_controller_if #(
  parameter int NEURON_W = 6,
  parameter int OFFSET_W = 10,
  parameter int CSR_AW   = 14,
  parameter int VOL_W    = 16
);
  logic [NEURON_W-1:0] offset_addr;
  logic [OFFSET_W-1:0] offset_value;
  logic [CSR_AW-1:0]   csr_addr;
  logic                wna_valid;
  logic                wna_ready;
  logic                load_voltage;
  logic                export_voltage;
  logic                vol_mem_init;
  logic [VOL_W-1:0]    init_mem_vol;

  modport master (
    output offset_addr, csr_addr, wna_valid, load_voltage, export_voltage,
           vol_mem_init, init_mem_vol,
    input  offset_value, wna_ready
  );

  modport slave (
    input  offset_addr, csr_addr, wna_valid, load_voltage, export_voltage,
           vol_mem_init, init_mem_vol,
    output offset_value, wna_ready
  );
endinterface
`default_nettype wire

// File: rtl/snn_ctrl_perf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_ctrl_perf - saturating run-cycle / stall-cycle counter pair
// Revision 1.0
// ----------------------------------------------------------------------------
module snn_ctrl_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        cycle_en,
  input  logic        stall_en,
  output logic [31:0] cycles,
  output logic [31:0] stalls
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
      stalls <= '0;
    end else if (clear) begin
      cycles <= '0;
      stalls <= '0;
    end else begin
      if (cycle_en && (cycles != '1)) cycles <= cycles + 32'd1;
      if (stall_en && (stalls != '1)) stalls <= stalls + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snn_layer_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snn_layer_controller - per-layer neuron/time-step sequencer for the SNN;
// SNN_CTRL_PERF_EN adds perf_cycles/perf_stalls counters. Revision 1.0
// ----------------------------------------------------------------------------
module snn_layer_controller
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_NEURONS = 40,
  parameter int NUM_STEPS   = 4,
  parameter int OFFSET_W    = 10,
  parameter int CSR_AW      = 14,
  parameter int VOL_W       = 16,
  parameter int INIT_VOL    = DEFAULT_INIT_VOL,
  parameter int NEURON_W    = $clog2(NUM_NEURONS),
  parameter int STEP_W      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  snn_layer_controller_if.master bus,
  output logic                  busy,
  output logic [STEP_W-1:0]     time_step,
  output logic                  step_done
`ifdef SNN_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);

  localparam logic [NEURON_W-1:0] LAST_N   = NEURON_W'(NUM_NEURONS - 1);
  localparam logic [STEP_W-1:0]   LAST_T   = STEP_W'(NUM_STEPS - 1);
  localparam logic [VOL_W-1:0]    INIT_V   = VOL_W'(INIT_VOL);
  localparam logic [OFFSET_W-1:0] REM_LAST = OFFSET_W'(1);

  state_t              state, state_nxt;
  logic [NEURON_W-1:0] n;
  logic [STEP_W-1:0]   t;
  logic [OFFSET_W-1:0] rem;
  logic [CSR_AW-1:0]   csr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n   <= '0;
      t   <= '0;
      rem <= '0;
      csr <= '0;
    end else begin
      case (state)
        S_INIT:  n <= (n == LAST_N) ? '0 : n + 1'b1;
        S_LATCH: rem <= bus.offset_value;
        S_ISSUE: begin
          if (bus.wna_ready) begin
            csr <= csr + 1'b1;
            rem <= rem - 1'b1;
          end
        end
        S_DUMP1: begin
          // CSR addressing restarts at each time step; it runs on across neurons.
          if (n == LAST_N) begin
            n   <= '0;
            csr <= '0;
            t   <= (t == LAST_T) ? '0 : t + 1'b1;
          end else begin
            n <= n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.offset_addr    = '0;
    bus.wna_valid      = 1'b0;
    bus.load_voltage   = 1'b0;
    bus.export_voltage = 1'b0;
    bus.vol_mem_init   = 1'b0;
    bus.init_mem_vol   = '0;
    step_done          = 1'b0;
    case (state)
      S_INIT: begin
        bus.vol_mem_init = 1'b1;
        bus.init_mem_vol = INIT_V;
        bus.offset_addr  = n;
        if (n == LAST_N) state_nxt = S_IDLE;
      end
      S_IDLE:  if (start) state_nxt = S_PULL;
      S_PULL: begin
        bus.offset_addr = n;
        state_nxt       = S_LATCH;
      end
      S_LATCH: begin
        bus.load_voltage = 1'b1;
        state_nxt = (bus.offset_value == '0) ? S_TIDY : S_GAP;
      end
      S_GAP:   state_nxt = S_ISSUE;
      S_ISSUE: begin
        bus.wna_valid = 1'b1;
        if (bus.wna_ready) state_nxt = (rem == REM_LAST) ? S_TIDY : S_GAP;
      end
      S_TIDY:  state_nxt = S_DUMP0;
      S_DUMP0: begin
        bus.export_voltage = 1'b1;
        state_nxt          = S_DUMP1;
      end
      S_DUMP1: begin
        bus.offset_addr = n;
        state_nxt = ((n == LAST_N) && (t == LAST_T)) ? S_DONE : S_PULL;
      end
      S_DONE: begin
        step_done = 1'b1;
        state_nxt = S_INIT;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign bus.csr_addr = csr;
  assign busy         = (state != S_IDLE);
  assign time_step    = t;

`ifdef SNN_CTRL_PERF_EN
  logic perf_clear, perf_cycle_en, perf_stall_en;

  // Run cycles span PULL..DUMP1, so the total equals start-to-step_done latency.
  assign perf_clear    = (state == S_IDLE) && start;
  assign perf_cycle_en = (state != S_IDLE) && (state != S_INIT) && (state != S_DONE);
  assign perf_stall_en = (state == S_ISSUE) && !bus.wna_ready;

  snn_ctrl_perf u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (perf_clear),
    .cycle_en (perf_cycle_en),
    .stall_en (perf_stall_en),
    .cycles   (perf_cycles),
    .stalls   (perf_stalls)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_layer_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_snn_layer_controller - randomized scoreboard bench for snn_layer_controller
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_snn_layer_controller;

  localparam int NN       = 40;
  localparam int NS       = 4;
  localparam int OFFSET_W = 10;
  localparam int CSR_AW   = 14;
  localparam int VOL_W    = 16;
  localparam int INIT_VOL = 63;
  localparam int NEURON_W = 6;
  localparam int STEP_W   = 2;
  localparam int BOUND    = 20000;

  typedef struct packed {
    logic [STEP_W-1:0] t;
    logic [CSR_AW-1:0] addr;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, step_done;
  logic [STEP_W-1:0] time_step;
`ifdef SNN_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  snn_layer_controller_if #(
    .NEURON_W(NEURON_W), .OFFSET_W(OFFSET_W), .CSR_AW(CSR_AW), .VOL_W(VOL_W)
  ) bus ();

  snn_layer_controller #(
    .NUM_NEURONS(NN), .NUM_STEPS(NS), .OFFSET_W(OFFSET_W), .CSR_AW(CSR_AW),
    .VOL_W(VOL_W), .INIT_VOL(INIT_VOL), .NEURON_W(NEURON_W), .STEP_W(STEP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus.master),
    .busy      (busy),
    .time_step (time_step),
    .step_done (step_done)
`ifdef SNN_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OFFSET_W-1:0] offs [NN];
  always @(posedge clk)
    bus.offset_value <= (int'(bus.offset_addr) < NN) ? offs[bus.offset_addr] : '0;

  beat_t               beat_q [$];
  logic [STEP_W-1:0]   load_q [$];
  logic [STEP_W-1:0]   exp_q  [$];
  int                  done_q [$];
  logic [NEURON_W-1:0] init_q [$];
  int                  stall_q[$];
  int                  n_vec = 0;
  int                  n_err = 0;
  int                  last_total = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Datapath backpressure: each beat consumes one planned stall count.
  initial begin
    bit in_beat = 0;
    int k = 0;
    bus.wna_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_beat = 0;
        bus.wna_ready = 1'b0;
      end else begin
        if (bus.wna_valid && !in_beat) begin
          in_beat = 1;
          k = (stall_q.size() != 0) ? stall_q.pop_front() : 0;
        end
        if (in_beat) begin
          if (k > 0) begin
            bus.wna_ready = 1'b0;
            k--;
          end else begin
            bus.wna_ready = 1'b1;
            in_beat = 0;
          end
        end else begin
          bus.wna_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: samples after the driver has set wna_ready for the next edge.
  initial begin
    logic              held = 1'b0;
    logic [CSR_AW-1:0] held_addr = '0;
    beat_t             b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (bus.vol_mem_init) begin
          if (init_q.size() == 0) chk("init_unexpected", 1, 0);
          else begin
            chk("init_addr", bus.offset_addr, init_q.pop_front());
            chk("init_vol", bus.init_mem_vol, INIT_VOL);
          end
        end
        if (bus.wna_valid) begin
          if (held) chk("stall_hold_addr", bus.csr_addr, held_addr);
          if (bus.wna_ready) begin
            held = 1'b0;
            if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
              b = beat_q.pop_front();
              chk("beat_addr", bus.csr_addr, b.addr);
              chk("beat_step", time_step, b.t);
            end
          end else begin
            held = 1'b1;
            held_addr = bus.csr_addr;
          end
        end else begin
          held = 1'b0;
        end
        if (bus.load_voltage) begin
          if (load_q.size() == 0) chk("load_unexpected", 1, 0);
          else chk("load_step", time_step, load_q.pop_front());
        end
        if (bus.export_voltage) begin
          if (exp_q.size() == 0) chk("export_unexpected", 1, 0);
          else chk("export_step", time_step, exp_q.pop_front());
        end
        if (step_done) begin
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_vol_mem_init", bus.vol_mem_init, 1);
    chk("rst_busy", busy, 1);
    chk("rst_offset_addr", bus.offset_addr, 0);
    chk("rst_csr_addr", bus.csr_addr, 0);
    chk("rst_time_step", time_step, 0);
    chk("rst_wna_valid", bus.wna_valid, 0);
    chk("rst_load", bus.load_voltage, 0);
    chk("rst_export", bus.export_voltage, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_init_vol", bus.init_mem_vol, INIT_VOL);
  endtask

  task automatic push_init();
    for (int i = 0; i < NN; i++) init_q.push_back(NEURON_W'(i));
  endtask

  // Reference model: expected beats, voltage events and end time from the offsets.
  // mode 0: no stalls, 1: random 0..3 per beat, 2: 7 stalls on beat index 1.
  task automatic start_run(input int mode);
    int total = 0;
    int beats = 0;
    int addr;
    for (int t = 0; t < NS; t++) begin
      addr = 0;
      for (int n = 0; n < NN; n++) begin
        load_q.push_back(STEP_W'(t));
        for (int k = 0; k < int'(offs[n]); k++) begin
          beat_q.push_back('{t: STEP_W'(t), addr: CSR_AW'(addr)});
          addr++;
          beats++;
        end
        exp_q.push_back(STEP_W'(t));
        total += 5 + 2 * int'(offs[n]);
      end
    end
    for (int i = 0; i < beats; i++) begin
      int s;
      s = (mode == 1) ? int'($urandom_range(0, 3)) : ((mode == 2 && i == 1) ? 7 : 0);
      stall_q.push_back(s);
      total += s;
    end
    last_total = total;
    push_init();
    @(negedge clk);
    done_q.push_back(cyc + 1 + total);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((busy !== 1'b0 || init_q.size() != 0 || done_q.size() != 0) && i < BOUND) begin
      @(negedge clk);
      i++;
    end
    #3;
    chk("idle_reached", (i < BOUND), 1);
    chk("idle_busy", busy, 0);
    chk("beats_left", beat_q.size(), 0);
    chk("loads_left", load_q.size(), 0);
    chk("exports_left", exp_q.size(), 0);
  endtask

  task automatic rand_offs(input int lo, input int hi);
    for (int n = 0; n < NN; n++) offs[n] = OFFSET_W'($urandom_range(lo, hi));
  endtask

  initial begin
    for (int n = 0; n < NN; n++) offs[n] = '0;
    @(negedge clk);
    #1;
    check_reset_vals();
    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();

    // All offsets 3, no backpressure.
    for (int n = 0; n < NN; n++) offs[n] = OFFSET_W'(3);
    start_run(0);
    chk("run_len_all3", last_total, NS * NN * 11);
    wait_idle();
`ifdef SNN_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, last_total);
    chk("perf_stalls_zero", perf_stalls, 0);
`endif

    // Zero-length row in the middle of the layer.
    for (int n = 0; n < NN; n++) offs[n] = OFFSET_W'(2);
    offs[5] = '0;
    start_run(0);
    wait_idle();

    // Long stall on the second beat of neuron 0.
    rand_offs(0, 4);
    offs[0] = OFFSET_W'(2 + $urandom_range(0, 2));
    start_run(2);
    wait_idle();
`ifdef SNN_CTRL_PERF_EN
    chk("perf_stalls_7", perf_stalls, 7);
`endif

    // Random rows and stalls; a start pulse mid-run must be ignored.
    rand_offs(0, 7);
    start_run(1);
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset during a beat in step 2.
    begin
      int i = 0;
      rand_offs(1, 5);
      start_run(1);
      while (!(time_step == 2'd2 && bus.wna_valid === 1'b1) && i < BOUND) begin
        @(negedge clk);
        i++;
      end
      chk("reached_step2_issue", (i < BOUND), 1);
      rst_n = 1'b0;
      beat_q.delete();
      load_q.delete();
      exp_q.delete();
      done_q.delete();
      init_q.delete();
      stall_q.delete();
      #1;
      check_reset_vals();
      repeat (2) @(negedge clk);
      push_init();
      rst_n = 1'b1;
      wait_idle();
    end

    // A normal run still works after the aborted one.
    rand_offs(0, 6);
    start_run(1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snn_layer_controller.md
# snn_layer_controller

Parametrised sequencer for one hidden layer of the bin-ratio ensemble SNN. After reset it initialises every neuron's membrane voltage. On `start` it walks all neurons over all time steps: it fetches each neuron's CSR row length from the offset memory, issues one weight/activation beat per CSR entry with backpressure, then exports the voltage. It sits between the pre-processing front end and the CSR weight memory / membrane-voltage datapath.

## Interface
Parameters:
- `NUM_NEURONS`, default 40: hidden neurons per layer.
- `NUM_STEPS`, default 4: time steps per inference.
- `OFFSET_W`, default 10: width of the CSR row length.
- `CSR_AW`, default 14: width of the CSR weight address.
- `VOL_W`, default 16: width of the membrane voltage.
- `INIT_VOL`, default 63: reset value of the membrane voltage.
- `NEURON_W`, default $clog2(NUM_NEURONS); `STEP_W`, default $clog2(NUM_STEPS) (minimum 1).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pre-processing done. Sampled only in IDLE.
- `offset_value` in OFFSET_W: offset memory read data. Valid one cycle after `offset_addr`.
- `wna_ready` in 1: datapath accepts the current beat.
- `offset_addr` out NEURON_W: offset memory address; also the voltage init address.
- `csr_addr` out CSR_AW: CSR weight/activation address.
- `wna_valid` out 1: beat valid.
- `load_voltage` out 1: load the neuron's voltage into the accumulator.
- `export_voltage` out 1: write the accumulator back / export it.
- `vol_mem_init` out 1: voltage memory init write enable.
- `init_mem_vol` out VOL_W: init write data. Equals INIT_VOL while `vol_mem_init` is high, else 0.
- `busy` out 1: high in every state except IDLE.
- `time_step` out STEP_W: current step index.
- `step_done` out 1: one-cycle pulse when the full inference completes.

## Operation
- States: INIT, IDLE, PULL, LATCH, GAP, ISSUE, TIDY, DUMP0, DUMP1, DONE.
- Counters: neuron `n`, step `t`, remaining entries `rem` (OFFSET_W), `csr_addr`.
- INIT:
  - `vol_mem_init`=1; `offset_addr`=n; n increments each cycle.
  - When n==NUM_NEURONS-1: n←0, go to IDLE.
- IDLE: `start` → PULL; otherwise stay in IDLE.
- PULL: `offset_addr`=n. Go to LATCH.
- LATCH:
  - rem←`offset_value`; `load_voltage`=1.
  - If `offset_value`==0, go to TIDY (a zero-length row issues no beats). Otherwise go to GAP.
- GAP: idle cycle for weight memory read latency. Go to ISSUE.
- ISSUE:
  - `wna_valid`=1 and stays high until `wna_ready`.
  - On handshake: csr_addr+1 and rem−1. If rem==1, go to TIDY; otherwise go to GAP.
  - Without `wna_ready`, hold state; `csr_addr` is held stable.
- TIDY: go to DUMP0.
- DUMP0: `export_voltage`=1. Go to DUMP1.
- DUMP1:
  - `offset_addr`=n.
  - If n==NUM_NEURONS-1 and t==NUM_STEPS-1: n←0, t←0, csr_addr←0, go to DONE.
  - Else if n==NUM_NEURONS-1: n←0, t+1, csr_addr←0, go to PULL.
  - Else: n+1, go to PULL.
- DONE: `step_done`=1. Go to INIT, which re-initialises voltages for the next inference.
- `csr_addr` is contiguous across neurons within a step and wraps modulo 2^CSR_AW with no flag.
- Outputs are Moore-decoded from the state register. Unlisted outputs are 0 in each state. An illegal state goes to INIT.

## Timing
- Reset values:
  - State INIT.
  - n, t, rem and `csr_addr` all 0.
  - All 1-bit outputs 0, except `vol_mem_init`=1 and `busy`=1, which follow from INIT.
  - `init_mem_vol`=INIT_VOL.
- Init sequence: NUM_NEURONS cycles, then IDLE.
- Per-neuron latency with `wna_ready` tied high: 5+2·offset cycles (PULL to DUMP1 inclusive); 5 cycles for offset 0.
- Each stall cycle adds 1.
- `start` is latched only in IDLE; a `start` pulse while busy is ignored.
- `rst_n` asserted mid-operation: the block returns immediately to INIT with all counters cleared. Any partial inference is discarded.

## Configuration
- `SNN_CTRL_PERF_EN` defined:
  - Adds output ports `perf_cycles` [31:0] and `perf_stalls` [31:0].
  - `perf_cycles` counts clocks from leaving IDLE to DONE; `perf_stalls` counts ISSUE cycles with `wna_ready`=0.
  - Both clear on leaving IDLE, freeze in IDLE, saturate at all-ones, and reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `snn_ctrl_pkg`: state enum type, state encoding constants, default INIT_VOL.
- One sub-module is natural: `snn_ctrl_perf`, the saturating counter pair, instantiated only under the macro.

## Test plan
- Reset, NUM_NEURONS=40:
  - `vol_mem_init` high for 40 cycles with `offset_addr` 0..39 and `init_mem_vol`=63.
  - Then IDLE with `busy`=0.
- All offsets 3, `wna_ready`=1, NUM_STEPS=4:
  - 3 beats per neuron with `csr_addr` 0..119 per step, reset to 0 at each step.
  - `step_done` pulses once after 4·40·11 cycles from `start`.
- Neuron 5 offset 0, others 2: no `wna_valid` for neuron 5; `load_voltage` and `export_voltage` each still pulse once.
- `wna_ready` low for 7 cycles on the 2nd beat of neuron 0:
  - `wna_valid` and `csr_addr`=1 held stable.
  - With the macro, `perf_stalls`=7.
- `rst_n` pulsed low mid-ISSUE in step 2: outputs return to reset values and INIT restarts at `offset_addr` 0.
- `start` pulsed during a run: ignored, and the run completes with normal timing.
